score_keeper: RTL and testbench

//  Game-score stage upstream of the sound controller and 7-seg display driver.

---
 rtl/score_keeper_pkg.sv | 7 +
 rtl/score_keeper_if.sv | 13 +
 rtl/score_keeper_bcd_digit.sv | 22 ++
 rtl/score_keeper.sv | 83 ++++++++
 tb/tb_score_keeper.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/score_keeper_pkg.sv
// score_keeper_pkg: game-phase encoding and BCD score geometry shared by the score keeper files.
package score_keeper_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_OVER = 2'd2} state_t;
    localparam int BCD_W = 4;
    localparam int NDIG = 4;
    localparam int SCORE_W = BCD_W * NDIG;
endpackage

// File: rtl/score_keeper_if.sv
// score_keeper_if: game control inputs and score/status outputs of the score keeper.
interface score_keeper_if;
    import score_keeper_pkg::*;
    logic               i_start;
    logic               i_collide;
    logic               o_running;
    logic               o_over;
    logic               o_milestone;
    logic [SCORE_W-1:0] o_score;
    logic [SCORE_W-1:0] o_hiscore;
    modport master (output i_start, i_collide, input o_running, o_over, o_milestone, o_score, o_hiscore);
    modport slave  (input i_start, i_collide, output o_running, o_over, o_milestone, o_score, o_hiscore);
endinterface

// File: rtl/score_keeper_bcd_digit.sv
// bcd_digit: one decimal digit of the score counter; carries out when stepping past 9.
module bcd_digit
    import score_keeper_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic             i_carry_in,
    output logic             o_carry_out,
    output logic [BCD_W-1:0] o_digit
);
    logic [BCD_W-1:0] r_digit;
    logic             w_step;
    assign w_step      = i_inc & i_carry_in;
    assign o_carry_out = w_step & (r_digit == BCD_W'(9));
    assign o_digit     = r_digit;
    always_ff @(posedge clk) begin
        if (!rst || i_clr) r_digit <= '0;
        else if (w_step) r_digit <= o_carry_out ? '0 : r_digit + 1'b1;
    end
endmodule

// File: rtl/score_keeper.sv
// score_keeper: IDLE/RUN/OVER game FSM advancing a 4-digit BCD score with a milestone pulse.
// Define HISCORE_EN to keep a best-score register; otherwise o_hiscore is tied to zero.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int TICK_DIV = 5_000_000,
    parameter int MS_DIGIT = 1
) (
    input logic           clk,
    input logic           rst,
    score_keeper_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    state_t             r_state, w_next;
    logic [PW-1:0]      r_pre;
    logic               r_start_d, r_col_d, r_running, r_over, r_milestone;
    logic               w_start_ev, w_col_ev, w_clr, w_tick, w_unused;
    logic [NDIG:0]      w_carry;
    logic [SCORE_W-1:0] w_score;
    assign w_start_ev = bus.i_start & ~r_start_d;
    assign w_col_ev   = bus.i_collide & ~r_col_d;
    // A collide in RUN both ends the game and swallows that cycle's point.
    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_tick = 1'b0;
        if (r_state == ST_RUN) begin
            w_next = w_col_ev ? ST_OVER : ST_RUN;
            w_tick = ~w_col_ev & (r_pre == P_LAST);
        end else if (w_start_ev) begin
            w_next = ST_RUN;
            w_clr  = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_pre       <= '0;
            r_start_d   <= 1'b0;
            r_col_d     <= 1'b0;
            r_running   <= 1'b0;
            r_over      <= 1'b0;
            r_milestone <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_start_d   <= bus.i_start;
            r_col_d     <= bus.i_collide;
            r_running   <= w_next == ST_RUN;
            r_over      <= w_next == ST_OVER;
            r_milestone <= w_carry[MS_DIGIT+1];
            r_pre       <= w_clr ? '0 : r_state != ST_RUN ? r_pre : r_pre == P_LAST ? '0 : r_pre + 1'b1;
        end
    end
    assign w_carry[0] = 1'b1;
    for (genvar d = 0; d < NDIG; d++) begin : g_dig
        bcd_digit u_digit (
            .clk         (clk),
            .rst         (rst),
            .i_clr       (w_clr),
            .i_inc       (w_tick),
            .i_carry_in  (w_carry[d]),
            .o_carry_out (w_carry[d+1]),
            .o_digit     (w_score[d*BCD_W +: BCD_W])
        );
    end
    assign w_unused        = w_carry[NDIG];
    assign bus.o_running   = r_running;
    assign bus.o_over      = r_over;
    assign bus.o_milestone = r_milestone;
    assign bus.o_score     = w_score;
`ifdef HISCORE_EN
    logic [SCORE_W-1:0] r_hiscore;
    // Score is frozen in OVER, so comparing every OVER cycle equals a one-shot update.
    always_ff @(posedge clk) begin
        if (!rst) r_hiscore <= '0;
        else if (r_state == ST_OVER && w_score > r_hiscore) r_hiscore <= w_score;
    end
    assign bus.o_hiscore = r_hiscore;
`else
    assign bus.o_hiscore = '0;
`endif
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: table vectors, directed game sequences and random play against an integer score model.
module tb_score_keeper;
    localparam int TD = 4;
    localparam int MS = 1;
    localparam int MS_MOD = 100;
`ifdef HISCORE_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif
    typedef struct {
        bit rst, st, co;
        bit run, ov, ms;
        logic [15:0] sc, hi;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_cmp = 0, n_bad = 0, n_ms = 0;
    int m_score, m_hi, m_pre;
    bit m_run, m_over, m_mile, m_ps, m_pc;
    vec_t tv[13];
    always #5 clk = ~clk;
    score_keeper_if bus ();
    score_keeper #(.TICK_DIV(TD), .MS_DIGIT(MS)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Game rules applied to an integer score, evaluated with the inputs present before the edge.
    task automatic model_step();
        bit sev, cev;
        sev = bus.i_start & ~m_ps;
        cev = bus.i_collide & ~m_pc;
        m_mile = 1'b0;
        if (!rst) begin
            m_score = 0; m_hi = 0; m_pre = 0;
            m_run = 0; m_over = 0; m_ps = 0; m_pc = 0;
        end else begin
            if (HI_EN && m_over && m_score > m_hi) m_hi = m_score;
            if (m_run) begin
                if (cev) begin
                    m_run = 0;
                    m_over = 1;
                end else begin
                    if (m_pre == TD - 1) begin
                        m_score = (m_score + 1) % 10000;
                        m_mile = (m_score % MS_MOD) == 0;
                    end
                    m_pre = (m_pre + 1) % TD;
                end
            end else if (sev) begin
                m_run = 1; m_over = 0; m_score = 0; m_pre = 0;
            end
            m_ps = bus.i_start;
            m_pc = bus.i_collide;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("running", 16'(bus.o_running), 16'(m_run));
        chk("over", 16'(bus.o_over), 16'(m_over));
        chk("milestone", 16'(bus.o_milestone), 16'(m_mile));
        chk("score", bus.o_score, to_bcd(m_score));
        chk("hiscore", bus.o_hiscore, to_bcd(m_hi));
        if (bus.o_milestone === 1'b1) n_ms++;
    endtask

    task automatic run_until(input logic [15:0] target, input int budget, input string name);
        int k = 0;
        while (bus.o_score !== target && k < budget) begin
            tick();
            k++;
        end
        chk(name, bus.o_score, target);
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_collide = 1'b0;
        tv = '{
            '{0,0,0, 0,0,0, 16'h0000, 16'h0000},
            '{0,0,0, 0,0,0, 16'h0000, 16'h0000},
            '{1,0,0, 0,0,0, 16'h0000, 16'h0000},
            '{1,1,0, 1,0,0, 16'h0000, 16'h0000},
            '{1,1,0, 1,0,0, 16'h0000, 16'h0000},
            '{1,0,0, 1,0,0, 16'h0000, 16'h0000},
            '{1,0,0, 1,0,0, 16'h0000, 16'h0000},
            '{1,0,0, 1,0,0, 16'h0001, 16'h0000},
            '{1,0,1, 0,1,0, 16'h0001, 16'h0000},
            '{1,0,0, 0,1,0, 16'h0001, 16'h0001},
            '{1,1,1, 1,0,0, 16'h0000, 16'h0001},
            '{1,0,1, 1,0,0, 16'h0000, 16'h0001},
            '{0,0,0, 0,0,0, 16'h0000, 16'h0000}
        };
        for (int i = 0; i < 13; i++) begin
            rst = tv[i].rst;
            bus.i_start = tv[i].st;
            bus.i_collide = tv[i].co;
            model_step();
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_running", i), 16'(bus.o_running), 16'(tv[i].run));
            chk($sformatf("tbl%0d_over", i), 16'(bus.o_over), 16'(tv[i].ov));
            chk($sformatf("tbl%0d_milestone", i), 16'(bus.o_milestone), 16'(tv[i].ms));
            chk($sformatf("tbl%0d_score", i), bus.o_score, tv[i].sc);
            chk($sformatf("tbl%0d_hiscore", i), bus.o_hiscore, tv[i].hi & {16{HI_EN}});
        end
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_collide = 1'b0;
        repeat (20) tick();
        chk("idle_score", bus.o_score, 16'h0000);
        n_ms = 0;
        bus.i_start = 1'b1;
        tick();
        chk("start_running", 16'(bus.o_running), 16'h0001);
        bus.i_start = 1'b0;
        repeat (40) tick();
        chk("score_after_40", bus.o_score, 16'h0010);
        run_until(16'h0100, 400, "reach_0100");
        chk("ms_at_0100", 16'(bus.o_milestone), 16'h0001);
        tick();
        chk("ms_one_cycle", 16'(bus.o_milestone), 16'h0000);
        chk("ms_count_to_0100", 16'(n_ms), 16'h0001);
        begin
            int k = 0;
            while (!(m_score == 123 && m_pre == TD - 1) && k < 200) begin
                tick();
                k++;
            end
        end
        chk("align_0123", bus.o_score, 16'h0123);
        bus.i_collide = 1'b1;
        tick();
        bus.i_collide = 1'b0;
        chk("over_at_0123", 16'(bus.o_over), 16'h0001);
        chk("frozen_0123", bus.o_score, 16'h0123);
        tick();
        chk("hiscore_0123", bus.o_hiscore, HI_EN ? 16'h0123 : 16'h0000);
        bus.i_start = 1'b1;
        tick();
        run_until(16'h0050, 400, "reach_0050");
        bus.i_collide = 1'b1;
        tick();
        bus.i_collide = 1'b0;
        repeat (100) tick();
        chk("held_start_no_restart", 16'(bus.o_running), 16'h0000);
        chk("held_start_score", bus.o_score, 16'h0050);
        chk("hiscore_kept", bus.o_hiscore, HI_EN ? 16'h0123 : 16'h0000);
        bus.i_start = 1'b0;
        tick();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        n_ms = 0;
        run_until(16'h9999, 41000, "reach_9999");
        run_until(16'h0000, 8, "wrap_0000");
        chk("ms_at_wrap", 16'(bus.o_milestone), 16'h0001);
        chk("ms_count_full", 16'(n_ms), 16'd100);
        repeat (30) tick();
        rst = 1'b0;
        tick();
        chk("rst_mid_run_running", 16'(bus.o_running), 16'h0000);
        chk("rst_mid_run_score", bus.o_score, 16'h0000);
        rst = 1'b1;
        repeat (3000) begin
            bus.i_start = ($urandom_range(0, 19) == 0);
            bus.i_collide = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 499) != 0);
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
